// File: rtl/id_stage_hazard.sv
// Decode stage with register file, operand forwarding, hazard stalls,
// branch/jump resolution in ID, an ID/EX pipeline register and a saturating stall counter.
module id_stage_hazard #(
  parameter int XLEN   = 32,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_instruction,
  input  logic [XLEN-1:0]   id_pc_4,
  input  logic              dec_useRs,
  input  logic              dec_useRt,
  input  logic [1:0]        dec_branch,
  input  logic              dec_jump,
  input  logic              dec_jal,
  input  logic              dec_regWrite,
  input  logic              dec_memRead,
  input  logic              dec_writeRtOrRd,
  input  logic              dec_zeroExt,
  input  logic              ex_regWrite,
  input  logic              ex_memRead,
  input  logic [4:0]        ex_writeAddr,
  input  logic [XLEN-1:0]   ex_aluResult,
  input  logic              mem_regWrite,
  input  logic [4:0]        mem_writeAddr,
  input  logic [XLEN-1:0]   mem_result,
  input  logic              wb_regWrite,
  input  logic [4:0]        wb_writeAddr,
  input  logic [XLEN-1:0]   wb_writeData,
  input  logic [4:0]        debug_addr,
  output logic [XLEN-1:0]   debug_data_reg,
  output logic              stall,
  output logic              redirect,
  output logic [XLEN-1:0]   redirectPc,
  output logic              idex_valid,
  output logic              idex_regWrite,
  output logic              idex_memRead,
  output logic [XLEN-1:0]   idex_rsData,
  output logic [XLEN-1:0]   idex_rtData,
  output logic [XLEN-1:0]   idex_imm,
  output logic [4:0]        idex_writeAddr,
  output logic [31:0]       idex_instruction,
  output logic [CNT_W-1:0]  stallCount
);

  localparam bit FWD = (FWD_EN != 0);

  logic [XLEN-1:0] regFile [32];
  logic [4:0]      rsAddr, rtAddr, rdAddr;
  logic [4:0]      srcAddr [2];
  logic            srcUse  [2];
  logic [XLEN-1:0] srcVal  [2];
  logic            srcHaz  [2];
  logic [XLEN-1:0] rsVal, rtVal, immSext, immZext, immVal, opA, opB;
  logic [4:0]      writeAddr;
  logic            isJr, taken;

  assign rsAddr     = id_instruction[25:21];
  assign rtAddr     = id_instruction[20:16];
  assign rdAddr     = id_instruction[15:11];
  assign srcAddr[0] = rsAddr;
  assign srcAddr[1] = rtAddr;
  assign srcUse[0]  = dec_useRs;
  assign srcUse[1]  = dec_useRt;

  always_ff @(posedge clk) begin
    if (rst) begin
      regFile <= '{default: '0};
    end else if (wb_regWrite && wb_writeAddr != 5'd0) begin
      regFile[wb_writeAddr] <= wb_writeData;
    end
  end

  assign debug_data_reg = regFile[debug_addr];

  // Later assignments override earlier ones, so the order below is lowest to highest priority.
  for (genvar g = 0; g < 2; g++) begin : gSrc
    always_comb begin
      srcVal[g] = regFile[srcAddr[g]];
      if (wb_regWrite && wb_writeAddr == srcAddr[g])
        srcVal[g] = wb_writeData;
      if (FWD && mem_regWrite && mem_writeAddr == srcAddr[g])
        srcVal[g] = mem_result;
      if (FWD && ex_regWrite && !ex_memRead && ex_writeAddr == srcAddr[g])
        srcVal[g] = ex_aluResult;
      if (srcAddr[g] == 5'd0)
        srcVal[g] = '0;
      srcHaz[g] = srcUse[g] && (srcAddr[g] != 5'd0) &&
                  ((ex_memRead && ex_writeAddr == srcAddr[g]) ||
                   (!FWD && ((ex_regWrite && ex_writeAddr == srcAddr[g]) ||
                             (mem_regWrite && mem_writeAddr == srcAddr[g]))));
    end
  end

  assign rsVal = srcVal[0];
  assign rtVal = srcVal[1];
  assign stall = id_valid && (srcHaz[0] || srcHaz[1]);

  assign immSext = {{(XLEN-16){id_instruction[15]}}, id_instruction[15:0]};
  assign immZext = {{(XLEN-16){1'b0}}, id_instruction[15:0]};
  assign immVal  = dec_zeroExt ? immZext : immSext;

  always_comb begin
    isJr  = (dec_branch == 2'b11);
    taken = dec_jump || isJr ||
            (dec_branch == 2'b01 && rsVal == rtVal) ||
            (dec_branch == 2'b10 && rsVal != rtVal);
    if (isJr)
      redirectPc = rsVal;
    else if (dec_jump)
      redirectPc = {id_pc_4[XLEN-1:28], id_instruction[25:0], 2'b00};
    else
      redirectPc = id_pc_4 + {immSext[XLEN-3:0], 2'b00};
  end

  assign redirect  = id_valid && !stall && taken;
  assign writeAddr = dec_jal ? 5'd31 : (dec_writeRtOrRd ? rtAddr : rdAddr);
  // jal hands EX pc_4 + 0 so the ordinary ALU add produces the link value.
  assign opA       = dec_jal ? id_pc_4 : rsVal;
  assign opB       = dec_jal ? '0 : rtVal;

  // Reset and bubble share one branch: a bubble clears every field, same as reset.
  always_ff @(posedge clk) begin
    if (rst || stall || !id_valid) begin
      idex_valid       <= 1'b0;
      idex_regWrite    <= 1'b0;
      idex_memRead     <= 1'b0;
      idex_rsData      <= '0;
      idex_rtData      <= '0;
      idex_imm         <= '0;
      idex_writeAddr   <= '0;
      idex_instruction <= '0;
    end else begin
      idex_valid       <= 1'b1;
      idex_regWrite    <= dec_regWrite;
      idex_memRead     <= dec_memRead;
      idex_rsData      <= opA;
      idex_rtData      <= opB;
      idex_imm         <= immVal;
      idex_writeAddr   <= writeAddr;
      idex_instruction <= id_instruction;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stallCount <= '0;
    else if (stall && stallCount != '1)
      stallCount <= stallCount + CNT_W'(1);
  end

endmodule

// File: tb/tb_id_stage_hazard.sv
// Bench for id_stage_hazard: three instances (forwarding, no forwarding, 2-bit counter)
// share stimulus and are compared against a behavioural model of the decode stage.
module tb_id_stage_hazard;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, id_valid;
  logic [31:0] id_instruction, id_pc_4;
  logic        dec_useRs, dec_useRt;
  logic [1:0]  dec_branch;
  logic        dec_jump, dec_jal, dec_regWrite, dec_memRead, dec_writeRtOrRd, dec_zeroExt;
  logic        ex_regWrite, ex_memRead;
  logic [4:0]  ex_writeAddr;
  logic [31:0] ex_aluResult;
  logic        mem_regWrite;
  logic [4:0]  mem_writeAddr;
  logic [31:0] mem_result;
  logic        wb_regWrite;
  logic [4:0]  wb_writeAddr;
  logic [31:0] wb_writeData;
  logic [4:0]  debug_addr;

  logic        stallO [3], redirO [3], ivO [3], irwO [3], imrO [3];
  logic [31:0] rpcO [3], rsO [3], rtO [3], immO [3], insO [3], dbgO [3];
  logic [4:0]  waO [3];
  logic [15:0] cntO [3];

  for (genvar g = 0; g < 3; g++) begin : gDut
    localparam int FW = (g == 1) ? 0 : 1;
    localparam int CW = (g == 2) ? 2 : 16;
    logic [CW-1:0] cnt;
    id_stage_hazard #(.XLEN(32), .FWD_EN(FW), .CNT_W(CW)) u (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_instruction(id_instruction),
      .id_pc_4(id_pc_4), .dec_useRs(dec_useRs), .dec_useRt(dec_useRt),
      .dec_branch(dec_branch), .dec_jump(dec_jump), .dec_jal(dec_jal),
      .dec_regWrite(dec_regWrite), .dec_memRead(dec_memRead),
      .dec_writeRtOrRd(dec_writeRtOrRd), .dec_zeroExt(dec_zeroExt),
      .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_writeAddr(ex_writeAddr),
      .ex_aluResult(ex_aluResult), .mem_regWrite(mem_regWrite),
      .mem_writeAddr(mem_writeAddr), .mem_result(mem_result),
      .wb_regWrite(wb_regWrite), .wb_writeAddr(wb_writeAddr), .wb_writeData(wb_writeData),
      .debug_addr(debug_addr), .debug_data_reg(dbgO[g]),
      .stall(stallO[g]), .redirect(redirO[g]), .redirectPc(rpcO[g]),
      .idex_valid(ivO[g]), .idex_regWrite(irwO[g]), .idex_memRead(imrO[g]),
      .idex_rsData(rsO[g]), .idex_rtData(rtO[g]), .idex_imm(immO[g]),
      .idex_writeAddr(waO[g]), .idex_instruction(insO[g]), .stallCount(cnt)
    );
    assign cntO[g] = 16'(cnt);
  end

  int tests = 0;
  int fails = 0;

  // Reference state
  logic [31:0] mRegs [32];
  int unsigned mCnt [3];
  logic        eV [3], eRw [3], eMr [3];
  logic [31:0] eRs [3], eRt [3], eImm [3], eIns [3];
  logic [4:0]  eWa [3];

  task automatic chk(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[%0d]: got %h expected %h", tag, g, obs, exp);
    end
  endtask

  function automatic logic [31:0] mkR(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] mkI(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Value an instruction in ID should see for register a.
  function automatic logic [31:0] mOperand(input bit fwd, input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (fwd && ex_regWrite && !ex_memRead && ex_writeAddr == a) return ex_aluResult;
    if (fwd && mem_regWrite && mem_writeAddr == a) return mem_result;
    if (wb_regWrite && wb_writeAddr == a) return wb_writeData;
    return mRegs[a];
  endfunction

  // True when register a cannot be supplied this cycle.
  function automatic bit mBlocked(input bit fwd, input logic [4:0] a);
    bit exWrites, memWrites;
    if (a == 5'd0) return 1'b0;
    if (ex_memRead && ex_writeAddr == a) return 1'b1;
    exWrites  = ex_regWrite && ex_writeAddr == a;
    memWrites = mem_regWrite && mem_writeAddr == a;
    return !fwd && (exWrites || memWrites);
  endfunction

  task automatic idle();
    rst = 1'b0; id_valid = 1'b0; id_instruction = '0; id_pc_4 = '0;
    dec_useRs = 1'b0; dec_useRt = 1'b0; dec_branch = 2'b00; dec_jump = 1'b0; dec_jal = 1'b0;
    dec_regWrite = 1'b0; dec_memRead = 1'b0; dec_writeRtOrRd = 1'b0; dec_zeroExt = 1'b0;
    ex_regWrite = 1'b0; ex_memRead = 1'b0; ex_writeAddr = '0; ex_aluResult = '0;
    mem_regWrite = 1'b0; mem_writeAddr = '0; mem_result = '0;
    wb_regWrite = 1'b0; wb_writeAddr = '0; wb_writeData = '0; debug_addr = '0;
  endtask

  // Checks combinational outputs and predicts the next register state.
  task automatic preEdge();
    logic [4:0]  rsA, rtA, rdA;
    logic [15:0] i16;
    logic [31:0] rv, tv, tgt;
    bit          fwd, s, taken, red;
    int          off;
    int unsigned cmax;
    #1;
    rsA = id_instruction[25:21];
    rtA = id_instruction[20:16];
    rdA = id_instruction[15:11];
    i16 = id_instruction[15:0];
    off = int'($signed(i16));
    for (int g = 0; g < 3; g++) begin
      fwd  = (g != 1);
      cmax = (g == 2) ? 3 : 65535;
      s  = id_valid && ((dec_useRs && mBlocked(fwd, rsA)) || (dec_useRt && mBlocked(fwd, rtA)));
      rv = mOperand(fwd, rsA);
      tv = mOperand(fwd, rtA);
      case (dec_branch)
        2'b01:   taken = (rv == tv);
        2'b10:   taken = (rv != tv);
        2'b11:   taken = 1'b1;
        default: taken = 1'b0;
      endcase
      taken = taken || dec_jump;
      if (dec_branch == 2'b11)  tgt = rv;
      else if (dec_jump)        tgt = {id_pc_4[31:28], id_instruction[25:0], 2'b00};
      else                      tgt = id_pc_4 + 32'(off * 4);
      red = id_valid && !s && taken;
      chk("stall", g, 32'(stallO[g]), 32'(s));
      chk("redirect", g, 32'(redirO[g]), 32'(red));
      if (red) chk("redirectPc", g, rpcO[g], tgt);
      if (rst || s || !id_valid) begin
        eV[g] = 0; eRw[g] = 0; eMr[g] = 0; eRs[g] = 0; eRt[g] = 0; eImm[g] = 0; eWa[g] = 0; eIns[g] = 0;
      end else begin
        eV[g]   = 1'b1;
        eRw[g]  = dec_regWrite;
        eMr[g]  = dec_memRead;
        eRs[g]  = dec_jal ? id_pc_4 : rv;
        eRt[g]  = dec_jal ? 32'd0 : tv;
        eImm[g] = dec_zeroExt ? {16'd0, i16} : 32'(off);
        eWa[g]  = dec_jal ? 5'd31 : (dec_writeRtOrRd ? rtA : rdA);
        eIns[g] = id_instruction;
      end
      if (rst) mCnt[g] = 0;
      else if (s && mCnt[g] < cmax) mCnt[g]++;
    end
    if (rst) begin
      for (int r = 0; r < 32; r++) mRegs[r] = 32'd0;
    end else if (wb_regWrite && wb_writeAddr != 5'd0) begin
      mRegs[wb_writeAddr] = wb_writeData;
    end
  endtask

  task automatic postEdge();
    @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("idex_valid", g, 32'(ivO[g]), 32'(eV[g]));
      chk("idex_regWrite", g, 32'(irwO[g]), 32'(eRw[g]));
      chk("idex_memRead", g, 32'(imrO[g]), 32'(eMr[g]));
      chk("idex_rsData", g, rsO[g], eRs[g]);
      chk("idex_rtData", g, rtO[g], eRt[g]);
      chk("idex_imm", g, immO[g], eImm[g]);
      chk("idex_writeAddr", g, 32'(waO[g]), 32'(eWa[g]));
      chk("idex_instruction", g, insO[g], eIns[g]);
      chk("stallCount", g, 32'(cntO[g]), mCnt[g]);
      chk("debug_data_reg", g, dbgO[g], mRegs[debug_addr]);
    end
    @(negedge clk);
  endtask

  task automatic step();
    preEdge();
    postEdge();
  endtask

  initial begin
    logic [31:0] r;
    for (int g = 0; g < 3; g++) mCnt[g] = 0;

    // Reset held two cycles
    idle(); rst = 1'b1;
    step(); step();
    for (int g = 0; g < 3; g++) begin
      chk("reset_valid", g, 32'(ivO[g]), 32'd0);
      chk("reset_count", g, 32'(cntO[g]), 32'd0);
    end

    // WB write of r5, then a reader
    idle(); wb_regWrite = 1; wb_writeAddr = 5; wb_writeData = 32'h1234;
    step();
    idle(); id_valid = 1; id_instruction = mkR(5, 0, 7); dec_useRs = 1; dec_regWrite = 1;
    step();
    chk("t1_rsData", 0, rsO[0], 32'h1234);
    chk("t1_valid", 0, 32'(ivO[0]), 32'd1);

    // EX forwarding beats same-cycle WB write
    idle(); ex_regWrite = 1; ex_writeAddr = 3; ex_aluResult = 32'hAA;
    wb_regWrite = 1; wb_writeAddr = 3; wb_writeData = 32'h55;
    id_valid = 1; id_instruction = mkR(3, 0, 8); dec_useRs = 1; dec_regWrite = 1;
    preEdge();
    chk("t2_stall", 0, 32'(stallO[0]), 32'd0);
    chk("t2_stallNoFwd", 1, 32'(stallO[1]), 32'd1);
    postEdge();
    chk("t2_rsData", 0, rsO[0], 32'hAA);

    // Load-use: one stall, then value from MEM
    idle(); ex_regWrite = 1; ex_memRead = 1; ex_writeAddr = 4;
    id_valid = 1; id_instruction = mkR(0, 4, 9); dec_useRt = 1; dec_regWrite = 1;
    preEdge();
    chk("t3_stall", 0, 32'(stallO[0]), 32'd1);
    postEdge();
    chk("t3_bubble", 0, 32'(ivO[0]), 32'd0);
    chk("t3_count", 0, 32'(cntO[0]), 32'd1);
    ex_regWrite = 0; ex_memRead = 0; ex_writeAddr = 0;
    mem_regWrite = 1; mem_writeAddr = 4; mem_result = 32'h77;
    preEdge();
    chk("t3_noStall", 0, 32'(stallO[0]), 32'd0);
    postEdge();
    chk("t3_rtData", 0, rtO[0], 32'h77);

    // beq / bne with equal operands
    idle(); wb_regWrite = 1; wb_writeAddr = 1; wb_writeData = 9; step();
    idle(); wb_regWrite = 1; wb_writeAddr = 2; wb_writeData = 9; step();
    idle(); id_valid = 1; id_instruction = mkI(6'h04, 1, 2, 16'hFFFE); id_pc_4 = 32'h100;
    dec_useRs = 1; dec_useRt = 1; dec_branch = 2'b01;
    preEdge();
    chk("t4_beqTaken", 0, 32'(redirO[0]), 32'd1);
    chk("t4_beqTarget", 0, rpcO[0], 32'hF8);
    postEdge();
    dec_branch = 2'b10;
    preEdge();
    chk("t4_bneNotTaken", 0, 32'(redirO[0]), 32'd0);
    postEdge();

    // No-forward build: ALU producer r6 then consumer
    idle(); id_valid = 1; id_instruction = mkR(6, 0, 10); dec_useRs = 1; dec_regWrite = 1;
    ex_regWrite = 1; ex_writeAddr = 6; ex_aluResult = 32'h66;
    preEdge(); chk("t5_stallEx", 1, 32'(stallO[1]), 32'd1); postEdge();
    ex_regWrite = 0; ex_writeAddr = 0;
    mem_regWrite = 1; mem_writeAddr = 6; mem_result = 32'h66;
    preEdge(); chk("t5_stallMem", 1, 32'(stallO[1]), 32'd1); postEdge();
    mem_regWrite = 0; mem_writeAddr = 0;
    wb_regWrite = 1; wb_writeAddr = 6; wb_writeData = 32'h66;
    preEdge(); chk("t5_noStallWb", 1, 32'(stallO[1]), 32'd0); postEdge();
    chk("t5_rsData", 1, rsO[1], 32'h66);
    chk("t5_valid", 1, 32'(ivO[1]), 32'd1);

    // Saturation of the 2-bit counter
    idle(); rst = 1; step();
    idle(); ex_regWrite = 1; ex_memRead = 1; ex_writeAddr = 4;
    id_valid = 1; id_instruction = mkR(4, 0, 11); dec_useRs = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t6_satCount", 2, 32'(cntO[2]), (k < 2) ? 32'(k + 1) : 32'd3);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      rst = ($urandom_range(0, 39) == 0);
      id_valid = ($urandom_range(0, 7) != 0);
      id_instruction = $urandom;
      id_instruction[25:21] = 5'($urandom_range(0, 7));
      id_instruction[20:16] = 5'($urandom_range(0, 7));
      id_pc_4 = $urandom;
      dec_useRs = r[0]; dec_useRt = r[1];
      dec_branch = r[3:2];
      dec_jump = (dec_branch == 2'b00) && (r[5:4] == 2'b00);
      dec_jal = dec_jump && r[6];
      dec_regWrite = r[7]; dec_memRead = r[8]; dec_writeRtOrRd = r[9]; dec_zeroExt = r[10];
      ex_regWrite = r[11]; ex_memRead = r[11] && r[12] && r[13];
      ex_writeAddr = 5'($urandom_range(0, 7));
      ex_aluResult = r[14] ? 32'($urandom_range(0, 3)) : $urandom;
      mem_regWrite = r[15];
      mem_writeAddr = 5'($urandom_range(0, 7));
      mem_result = r[16] ? 32'($urandom_range(0, 3)) : $urandom;
      wb_regWrite = r[17];
      wb_writeAddr = 5'($urandom_range(0, 7));
      wb_writeData = r[18] ? 32'($urandom_range(0, 3)) : $urandom;
      debug_addr = 5'($urandom_range(0, 7));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_stage_hazard.md
# id_stage_hazard

Parametrised decode-stage successor: holds the register file and resolves branches in ID, like the current decode stage. Adds EX/MEM/WB operand forwarding, load-use and no-forward hazard stalls, and an internal ID/EX pipeline register with bubble insertion. Adds a saturating stall counter. Sits between the IF/ID register and the EX stage; the opcode decoder stays external and feeds `dec_*` strobes.

## Interface
- `XLEN`, 32: datapath and PC width, ≥32; instruction is always 32 bits.
- `FWD_EN`, 1: 1 enables EX/MEM forwarding; 0 stalls on any EX/MEM destination match.
- `CNT_W`, 16: stall counter width.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: IF/ID holds a real instruction.
- `id_instruction` in 32; `id_pc_4` in XLEN.
- `dec_useRs`, `dec_useRt` in 1: source operands actually read.
- `dec_branch` in 2: 00 none, 01 beq, 10 bne, 11 jr.
- `dec_jump`, `dec_jal`, `dec_regWrite`, `dec_memRead`, `dec_writeRtOrRd`, `dec_zeroExt` in 1 each. `dec_writeRtOrRd` set means the destination is rt.
- `ex_regWrite`, `ex_memRead` in 1; `ex_writeAddr` in 5; `ex_aluResult` in XLEN.
- `mem_regWrite` in 1; `mem_writeAddr` in 5; `mem_result` in XLEN: final MEM value, load data if load.
- `wb_regWrite` in 1; `wb_writeAddr` in 5; `wb_writeData` in XLEN.
- `debug_addr` in 5; `debug_data_reg` out XLEN: raw register file read.
- `stall` out 1: combinational; hold PC and IF/ID.
- `redirect` out 1; `redirectPc` out XLEN: combinational.
- `idex_valid`, `idex_regWrite`, `idex_memRead` out 1.
- `idex_rsData`, `idex_rtData`, `idex_imm` out XLEN; `idex_writeAddr` out 5; `idex_instruction` out 32.
- `stallCount` out CNT_W.

## Operation
- Register file: 32×XLEN, 2 read ports, 1 write port. r0 reads 0 and ignores writes.
- WB write-through: a same-cycle read of `wb_writeAddr` returns `wb_writeData`.
- Operand select for rs and rt, highest priority first:
  - address 0 → 0;
  - EX match (`ex_regWrite`, not `ex_memRead`, FWD_EN=1) → `ex_aluResult`;
  - MEM match (FWD_EN=1) → `mem_result`;
  - register file with WB write-through.
- Stall condition: `id_valid` and a used source (rs or rt, nonzero) matches any of the following.
  - EX destination with `ex_memRead` (load-use).
  - With FWD_EN=0, any EX or MEM destination with regWrite set.
- Branch resolution uses the forwarded values.
  - beq taken if rs==rt; bne taken if rs!=rt; jr always; dec_jump always.
- `redirect` = id_valid & !stall & taken. `redirectPc` is selected as follows.
  - jr → rs.
  - jump → {pc_4[XLEN-1:28], instr[25:0], 2'b0}.
  - branch → pc_4 + (sext(instr[15:0]) << 2), mod 2^XLEN.
- Immediate: zero-extended if `dec_zeroExt`, else sign-extended, to XLEN.
- Write address: 31 if `dec_jal`; rt if `dec_writeRtOrRd`; else rd.
- jal operands: rsData = pc_4 and rtData = 0, so EX computes the link value.
- ID/EX register update each cycle:
  - `rst` → all outputs 0.
  - `stall` or !id_valid → bubble: idex_valid, idex_regWrite and idex_memRead are 0; data fields are don't-care but driven to 0.
  - otherwise → capture all fields, idex_valid=1.
- `stallCount`: increments when id_valid & stall; saturates at 2^CNT_W−1; 0 on reset.

## Timing
- Reset: every `idex_*` output and `stallCount` read 0 on the cycle after `rst` is sampled high. Register file contents are all cleared to 0.
- `rst` mid-stall: the bubble is discarded and the counter clears; the stall output is recomputed from the inputs.
- Stall and redirect are combinational from inputs the same cycle; the ID/EX register has one-cycle latency.
- Load-use with FWD_EN=1: exactly 1 stall cycle. The load then sits in MEM, and the value comes from `mem_result`.
- FWD_EN=0: at most 2 stall cycles; the producer in WB is covered by write-through.
- A WB write and an ID read of the same register in the same cycle return the new data. The write commits at that edge.

## Test plan
1. Reset check: reset with `rst` high for 2 cycles, then write r5=0x1234 via WB. A following `add` reading r5 → `idex_rsData`=0x1234, `idex_valid`=1.
2. EX forward: `ex_aluResult`=0xAA with EX dest r3, and WB writing r3=0x55 in the same cycle. A consumer of r3 → `idex_rsData`=0xAA, `stall`=0.
3. Load-use: `ex_memRead`=1 with dest r4, and ID reads r4 → `stall`=1 for 1 cycle, bubble (`idex_valid`=0), `stallCount`=1. Next cycle `mem_result`=0x77 → `idex_rtData`=0x77.
4. Branch: beq with r1=r2=9, `id_pc_4`=0x100, imm=−2 → `redirect`=1, `redirectPc`=0xF8. Repeat as bne → `redirect`=0.
5. FWD_EN=0 build, ALU producer r6 followed by its consumer → 2 stall cycles, then the correct value arrives from WB write-through.
6. Saturation: CNT_W=2, hold a load-use stall for 5 cycles → `stallCount` sequence 1, 2, 3, 3, 3.
